// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH product.
// Optional early exit on uniform remaining multiplier bits: define BOOTH_EARLY_EXIT_EN.
module booth_mult_seq #(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicando,
    input  logic [WIDTH-1:0]     multiplicador,
    output logic                 busy,
    output logic                 Fin,
    output logic [2*WIDTH-1:0]   resultado,
    output logic [1:0]           dbg_state_o
);

    // Handshake: start is accepted only in IDLE; busy covers LOAD and CALC;
    // Fin is a one-cycle pulse in DONE; resultado holds until the next product lands.

    localparam int CW = $clog2(WIDTH + 1);
    // Working vector {A, Q, q_-1}: A carries one sign-guard bit
    localparam int VW = 2 * WIDTH + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_cap_q, mcand_cap_d;
    logic [WIDTH-1:0]   mplier_cap_q, mplier_cap_d;
    logic [2*WIDTH-1:0] res_q, res_d;

    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     a_step;
    logic [VW-1:0]      shift_vec;

    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        case ({q_q[0], qm1_q})
            2'b10:   a_step = a_q - m_ext;
            2'b01:   a_step = a_q + m_ext;
            default: a_step = a_q;
        endcase
        // Arithmetic right shift of {a_step, Q, q_-1} by one place
        shift_vec = {a_step[WIDTH], a_step, q_q};
    end

`ifdef BOOTH_EARLY_EXIT_EN
    logic [WIDTH:0] pend_mask;
    logic [WIDTH:0] pend_bits;
    logic [VW-1:0]  cur_vec;
    logic [VW-1:0]  exit_vec;
    logic           early_exit;

    // The low cnt bits of Q are still unprocessed; with q_-1 they decide
    // whether every remaining step is a pure shift.
    always_comb begin
        pend_mask  = {(WIDTH+1){1'b1}} >> (WIDTH - int'(cnt_q));
        pend_bits  = {q_q, qm1_q} & pend_mask;
        early_exit = (pend_bits == '0) || (pend_bits == pend_mask);
        cur_vec    = {a_q, q_q, qm1_q};
        exit_vec   = VW'($signed(cur_vec) >>> cnt_q);
    end
`endif

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        q_d          = q_q;
        m_d          = m_q;
        qm1_d        = qm1_q;
        cnt_d        = cnt_q;
        mcand_cap_d  = mcand_cap_q;
        mplier_cap_d = mplier_cap_q;
        res_d        = res_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_cap_d  = multiplicando;
                    mplier_cap_d = multiplicador;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                m_d     = mcand_cap_q;
                q_d     = mplier_cap_q;
                a_d     = '0;
                qm1_d   = 1'b0;
                cnt_d   = CW'(WIDTH);
                state_d = S_CALC;
            end
            S_CALC: begin
`ifdef BOOTH_EARLY_EXIT_EN
                if (early_exit) begin
                    {a_d, q_d, qm1_d} = exit_vec;
                    res_d             = exit_vec[VW-2:1];
                    state_d           = S_DONE;
                end else
`endif
                begin
                    {a_d, q_d, qm1_d} = shift_vec;
                    if (cnt_q == CW'(1)) begin
                        // Product is {A[WIDTH-1:0], Q} after the final shift
                        res_d   = shift_vec[VW-2:1];
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            q_q          <= '0;
            m_q          <= '0;
            qm1_q        <= 1'b0;
            cnt_q        <= '0;
            mcand_cap_q  <= '0;
            mplier_cap_q <= '0;
            res_q        <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            q_q          <= q_d;
            m_q          <= m_d;
            qm1_q        <= qm1_d;
            cnt_q        <= cnt_d;
            mcand_cap_q  <= mcand_cap_d;
            mplier_cap_q <= mplier_cap_d;
            res_q        <= res_d;
        end
    end

    assign busy        = (state_q == S_LOAD) || (state_q == S_CALC);
    assign Fin         = (state_q == S_DONE);
    assign resultado   = res_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed vectors at WIDTH 3 and 8,
// plus a full WIDTH=4 operand sweep against signed integer products.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start3, start4, start8;
    logic [7:0] m_in, q_in;

    logic       busy3, fin3, busy4, fin4, busy8, fin8;
    logic [5:0] res3;
    logic [7:0] res4;
    logic [15:0] res8;
    logic [1:0] dbg3, dbg4, dbg8;

    booth_mult_seq #(.WIDTH(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .multiplicando(m_in[2:0]), .multiplicador(q_in[2:0]),
        .busy(busy3), .Fin(fin3), .resultado(res3), .dbg_state_o(dbg3)
    );

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .multiplicando(m_in[3:0]), .multiplicador(q_in[3:0]),
        .busy(busy4), .Fin(fin4), .resultado(res4), .dbg_state_o(dbg4)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8),
        .multiplicando(m_in), .multiplicador(q_in),
        .busy(busy8), .Fin(fin8), .resultado(res8), .dbg_state_o(dbg8)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic sel_fin(input int w);
        case (w)
            3:       return fin3;
            4:       return fin4;
            default: return fin8;
        endcase
    endfunction

    function automatic logic sel_busy(input int w);
        case (w)
            3:       return busy3;
            4:       return busy4;
            default: return busy8;
        endcase
    endfunction

    function automatic logic [15:0] sel_res(input int w);
        case (w)
            3:       return {10'd0, res3};
            4:       return {8'd0, res4};
            default: return res8;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            3:       start3 = v;
            4:       start4 = v;
            default: start8 = v;
        endcase
    endtask

    // One operation: start for one cycle, scramble operands after accept,
    // count edges from the accept edge until Fin, and busy cycles on the way.
    task automatic run_op(input int w, input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp, output int lat, output int busy_n);
        @(negedge clk);
        m_in = m;
        q_in = q;
        set_start(w, 1'b1);
        @(posedge clk);
        lat    = 1;
        busy_n = 0;
        @(negedge clk);
        set_start(w, 1'b0);
        m_in = ~m;
        q_in = q + 8'd1;
        while (!sel_fin(w) && lat < 40) begin
            if (sel_busy(w)) busy_n++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("fin_seen", 32'(sel_fin(w)), 32'd1);
        check("product", 32'(sel_res(w)), 32'(exp));
        @(negedge clk);
        check("fin_pulse", 32'(sel_fin(w)), 32'd0);
        check("res_hold", 32'(sel_res(w)), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busy_n, fin_n, first, second;
        logic [15:0] got;
        logic [15:0] ent;
        logic [7:0]  p8;

        reset  = 1'b1;
        start3 = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;
        m_in   = '0;
        q_in   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res3", 32'(res3), 32'd0);
        check("rst_busy3", 32'(busy3), 32'd0);
        check("rst_fin3", 32'(fin3), 32'd0);
        check("rst_state3", 32'(dbg3), 32'd0);
        check("rst_res4", 32'(res4), 32'd0);
        check("rst_busy4", 32'({busy4, fin4, dbg4}), 32'd0);
        check("rst_res8", 32'(res8), 32'd0);
        check("rst_busy8", 32'({busy8, fin8, dbg8}), 32'd0);
        reset = 1'b0;

        // 3 * -2 = -6
        run_op(3, 8'h03, 8'h06, 16'h003A, lat, busy_n);
        check("t1_lat", 32'(lat), 32'd5);
        // -4 * -4 = +16, exercises the A sign guard
        run_op(3, 8'h04, 8'h04, 16'h0010, lat, busy_n);
        check("t2_lat", 32'(lat), 32'd5);
        check("t2_busy", 32'(busy_n), 32'd4);
        // -128 * -128 = +16384
        run_op(8, 8'h80, 8'h80, 16'h4000, lat, busy_n);
        check("t3_lat", 32'(lat), 32'd10);
        check("t3_busy", 32'(busy_n), 32'd9);
        // 127 * -127 = -16129
        run_op(8, 8'h7F, 8'h81, 16'hC0FF, lat, busy_n);
        check("t3b_lat", 32'(lat), 32'd10);

        // start pulsed during CALC with other operands is ignored
        @(negedge clk);
        m_in   = 8'h02;
        q_in   = 8'h03;
        start3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start3 = 1'b0;
        fin_n  = 0;
        got    = '0;
        for (int i = 0; i < 12; i++) begin
            if (fin3) begin
                fin_n++;
                got = {10'd0, res3};
            end
            if (i == 1) begin
                start3 = 1'b1;
                m_in   = 8'h07;
                q_in   = 8'h01;
            end else begin
                start3 = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("t4_fin_count", 32'(fin_n), 32'd1);
        check("t4_product", 32'(got), 32'h06);
        check("t4_held", 32'(res3), 32'h06);

        // start held high re-triggers: DONE, IDLE, LOAD, 3x CALC, DONE
        @(negedge clk);
        m_in   = 8'h01;
        q_in   = 8'hFF;
        start3 = 1'b1;
        first  = -1;
        second = -1;
        for (int i = 0; i < 30 && second < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (fin3) begin
                if (first < 0) first = i;
                else second = i;
            end
        end
        start3 = 1'b0;
        check("b2b_gap", 32'(second - first), 32'd6);
        check("b2b_product", 32'(res3), 32'h3F);
        repeat (2) @(negedge clk);

        // reset in the middle of an operation aborts it
        m_in   = 8'h03;
        q_in   = 8'h03;
        start3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("t5_busy", 32'(busy3), 32'd0);
        check("t5_fin", 32'(fin3), 32'd0);
        check("t5_res", 32'(res3), 32'd0);
        check("t5_state", 32'(dbg3), 32'd0);
        fin_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (fin3) fin_n++;
        end
        check("t5_no_fin", 32'(fin_n), 32'd0);
        run_op(3, 8'h03, 8'h03, 16'h0009, lat, busy_n);
        check("t5_lat", 32'(lat), 32'd5);

        // uniform multiplier bits: early exit when enabled, full latency otherwise
        run_op(3, 8'h05, 8'h00, 16'h0000, lat, busy_n);
`ifdef BOOTH_EARLY_EXIT_EN
        check("t6_lat_q0", 32'(lat), 32'd3);
`else
        check("t6_lat_q0", 32'(lat), 32'd5);
`endif
        run_op(8, 8'h05, 8'h01, 16'h0005, lat, busy_n);
`ifdef BOOTH_EARLY_EXIT_EN
        check("t6_lat_q1", 32'(lat < 10), 32'd1);
`else
        check("t6_lat_q1", 32'(lat), 32'd10);
`endif

        // WIDTH=4 sweep: expected queue holds {M, Q, product}
        for (int a = -8; a < 8; a++) begin
            for (int b = -8; b < 8; b++) begin
                p8 = 8'(a * b);
                exp_q.push_back({4'(a), 4'(b), p8});
            end
        end
        while (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            run_op(4, {4'd0, ent[15:12]}, {4'd0, ent[11:8]}, {8'd0, ent[7:0]}, lat, busy_n);
`ifdef BOOTH_EARLY_EXIT_EN
            check("sweep_lat", 32'(lat >= 3 && lat <= 6), 32'd1);
`else
            check("sweep_lat", 32'(lat), 32'd6);
`endif
        end
        check("sweep_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
